// File: rtl/hybrid_branch_predictor_pkg.sv
// Shared types and helpers for the Chronos tournament branch predictor.
// Counter helpers take the counter width as an argument so one package serves every table.
package chronos_bp_pkg;

  typedef enum logic {
    INIT,
    RUN
  } bp_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Weakly not-taken / weakly local starting value.
  function automatic int unsigned ctr_init(input int unsigned bits);
    return (32'd1 << (bits - 1)) - 1;
  endfunction

  function automatic int unsigned sat_step(input int unsigned val, input logic up,
                                           input int unsigned bits);
    int unsigned top_val;
    top_val = (32'd1 << bits) - 1;
    if (up) return (val >= top_val) ? val : val + 1;
    else    return (val == 0) ? val : val - 1;
  endfunction

endpackage

// File: rtl/hybrid_branch_predictor_if.sv
// Fetch-lookup and execute-update signals between the core and the branch predictor.
interface hybrid_branch_predictor_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned GHR_BITS = 8
);
  logic                ready;
  logic [XLEN-1:0]     lookup_pc;
  logic                pred_taken;
  logic [XLEN-1:0]     pred_target;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                update_valid;
  logic [XLEN-1:0]     update_pc;
  logic                update_taken;
  logic [XLEN-1:0]     update_target;
  logic                update_is_cond;
  logic [GHR_BITS-1:0] update_ghr;

  modport master (
    input  ready, pred_taken, pred_target, pred_ghr,
    output lookup_pc, update_valid, update_pc, update_taken, update_target,
           update_is_cond, update_ghr
  );

  modport slave (
    output ready, pred_taken, pred_target, pred_ghr,
    input  lookup_pc, update_valid, update_pc, update_taken, update_target,
           update_is_cond, update_ghr
  );
endinterface

// File: rtl/hybrid_branch_predictor_sat_counter_table.sv
// Table of saturating counters: combinational direction read, read-modify-write step port,
// and an init port used by the post-reset walk (init has priority).
module sat_counter_table import chronos_bp_pkg::*; #(
  parameter  int unsigned DEPTH = 256,
  parameter  int unsigned WIDTH = 2,
  localparam int unsigned IW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [IW-1:0]    rd_idx,
  output logic             rd_msb,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic             wr_up,
  output logic [WIDTH-1:0] wr_old,
  input  logic             init_en,
  input  logic [IW-1:0]    init_idx
);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(ctr_init(WIDTH));

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wr_next;

  assign rd_msb  = mem[rd_idx][WIDTH-1];
  assign wr_old  = mem[wr_idx];
  assign wr_next = WIDTH'(sat_step(32'(wr_old), wr_up, WIDTH));

  always_ff @(posedge clk) begin
    if (init_en)    mem[init_idx] <= INIT_VAL;
    else if (wr_en) mem[wr_idx]   <= wr_next;
  end
endmodule

// File: rtl/hybrid_branch_predictor.sv
// Tournament predictor: bimodal + gshare PHTs, chooser, direct-mapped BTB, and a
// post-reset walk that initialises every table one entry per cycle.
module hybrid_branch_predictor import chronos_bp_pkg::*; #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned PHT_ENTRIES = 256,
  parameter int unsigned GHR_BITS    = 8,
  parameter int unsigned CTR_BITS    = 2
) (
  input logic                     clk,
  input logic                     rst,
  hybrid_branch_predictor_if.slave bp
);
  localparam int unsigned PIW  = clog2(PHT_ENTRIES);
  localparam int unsigned BIW  = clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = XLEN - BIW - 2;
  localparam int unsigned N    = (PHT_ENTRIES > BTB_ENTRIES) ? PHT_ENTRIES : BTB_ENTRIES;
  localparam int unsigned CW   = clog2(N);
  localparam int unsigned CMSB = CTR_BITS - 1;

  bp_state_e           state;
  logic                ready_q;
  logic [CW-1:0]       cnt;
  logic [GHR_BITS-1:0] ghr;

  // Init walk
  logic           init_active, pht_init_en, btb_init_en;
  logic [PIW-1:0] pht_init_idx;
  logic [BIW-1:0] btb_init_idx;

  assign init_active  = (state == INIT) && !rst;
  assign pht_init_en  = init_active && (32'(cnt) < PHT_ENTRIES);
  assign btb_init_en  = init_active && (32'(cnt) < BTB_ENTRIES);
  assign pht_init_idx = cnt[PIW-1:0];
  assign btb_init_idx = cnt[BIW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + CW'(1);
      if (cnt == CW'(N - 1)) begin
        state   <= RUN;
        ready_q <= 1'b1;
      end
    end
  end

  // Index fields
  logic [PIW-1:0]  l_lidx, l_gidx, u_lidx, u_gidx;
  logic [BIW-1:0]  l_bidx, u_bidx;
  logic [TAGW-1:0] l_tag, u_tag;

  assign l_lidx = bp.lookup_pc[PIW+1:2];
  assign l_gidx = l_lidx ^ PIW'(ghr);
  assign l_bidx = bp.lookup_pc[BIW+1:2];
  assign l_tag  = bp.lookup_pc[XLEN-1:BIW+2];
  assign u_lidx = bp.update_pc[PIW+1:2];
  assign u_gidx = u_lidx ^ PIW'(bp.update_ghr);
  assign u_bidx = bp.update_pc[BIW+1:2];
  assign u_tag  = bp.update_pc[XLEN-1:BIW+2];

  // Update control
  logic                upd_run, pht_wr, disagree, glb_right;
  logic                loc_wr, glb_wr, cho_wr;
  logic                loc_msb, glb_msb, cho_msb;
  logic [CTR_BITS-1:0] loc_old, glb_old, cho_old;

  assign upd_run   = ready_q && bp.update_valid;
  assign pht_wr    = upd_run && bp.update_is_cond;
  assign disagree  = loc_old[CMSB] ^ glb_old[CMSB];
  assign glb_right = (glb_old[CMSB] == bp.update_taken);

  // Writes that would leave a saturated counter unchanged are suppressed.
  assign loc_wr = pht_wr && !(bp.update_taken ? (loc_old == '1) : (loc_old == '0));
  assign glb_wr = pht_wr && !(bp.update_taken ? (glb_old == '1) : (glb_old == '0));
  assign cho_wr = pht_wr && disagree && !(glb_right ? (cho_old == '1) : (cho_old == '0));

  sat_counter_table #(.DEPTH(PHT_ENTRIES), .WIDTH(CTR_BITS)) u_local_pht (
    .clk     (clk),
    .rd_idx  (l_lidx),
    .rd_msb  (loc_msb),
    .wr_en   (loc_wr),
    .wr_idx  (u_lidx),
    .wr_up   (bp.update_taken),
    .wr_old  (loc_old),
    .init_en (pht_init_en),
    .init_idx(pht_init_idx)
  );

  sat_counter_table #(.DEPTH(PHT_ENTRIES), .WIDTH(CTR_BITS)) u_global_pht (
    .clk     (clk),
    .rd_idx  (l_gidx),
    .rd_msb  (glb_msb),
    .wr_en   (glb_wr),
    .wr_idx  (u_gidx),
    .wr_up   (bp.update_taken),
    .wr_old  (glb_old),
    .init_en (pht_init_en),
    .init_idx(pht_init_idx)
  );

  sat_counter_table #(.DEPTH(PHT_ENTRIES), .WIDTH(CTR_BITS)) u_chooser (
    .clk     (clk),
    .rd_idx  (l_lidx),
    .rd_msb  (cho_msb),
    .wr_en   (cho_wr),
    .wr_idx  (u_lidx),
    .wr_up   (glb_right),
    .wr_old  (cho_old),
    .init_en (pht_init_en),
    .init_idx(pht_init_idx)
  );

  // BTB
  logic            btb_valid  [BTB_ENTRIES];
  logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0] btb_target [BTB_ENTRIES];
  logic            btb_jump   [BTB_ENTRIES];

  always_ff @(posedge clk) begin
    if (btb_init_en) begin
      btb_valid[btb_init_idx] <= 1'b0;
    end else if (upd_run && bp.update_taken) begin
      btb_valid[u_bidx]  <= 1'b1;
      btb_tag[u_bidx]    <= u_tag;
      btb_target[u_bidx] <= bp.update_target;
      btb_jump[u_bidx]   <= !bp.update_is_cond;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         ghr <= '0;
    else if (pht_wr) ghr <= {ghr[GHR_BITS-2:0], bp.update_taken};
  end

  // Lookup
  logic hit, direction, taken;

  assign hit       = btb_valid[l_bidx] && (btb_tag[l_bidx] == l_tag);
  assign direction = cho_msb ? glb_msb : loc_msb;
  assign taken     = ready_q && hit && (btb_jump[l_bidx] || direction);

  assign bp.ready       = ready_q;
  assign bp.pred_taken  = taken;
  assign bp.pred_target = taken ? btb_target[l_bidx] : bp.lookup_pc + XLEN'(4);
  assign bp.pred_ghr    = ghr;
endmodule

// File: tb/tb_hybrid_branch_predictor.sv
// Vector-table bench for hybrid_branch_predictor; expected lookups are queued at drive
// time and compared on the falling edge, before the update commits.
module tb_hybrid_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hybrid_branch_predictor_if #(.XLEN(32), .GHR_BITS(8)) bp ();

  hybrid_branch_predictor #(
    .XLEN(32), .BTB_ENTRIES(64), .PHT_ENTRIES(256), .GHR_BITS(8), .CTR_BITS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bp)
  );

  typedef struct {
    bit          pre_reset;
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        uc;
    logic [7:0]  ughr;
    logic        exp_taken;
    logic [31:0] exp_target;
    logic [7:0]  exp_ghr;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [7:0]  ghr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input bit pr, input logic [31:0] lpc, input logic uv,
                              input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                              input logic uc, input logic [7:0] ughr, input logic et,
                              input logic [31:0] etgt, input logic [7:0] eghr);
    vec_t v;
    v.pre_reset = pr; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.uc = uc; v.ughr = ughr; v.exp_taken = et; v.exp_target = etgt; v.exp_ghr = eghr;
    vecs.push_back(v);
  endfunction

  // Reset pulse plus init walk, with a would-be update held active the whole time.
  task automatic reset_walk();
    int k;
    bp.lookup_pc      = 32'h100;
    bp.update_valid   = 1'b1;
    bp.update_pc      = 32'h100;
    bp.update_taken   = 1'b1;
    bp.update_target  = 32'h80;
    bp.update_is_cond = 1'b1;
    bp.update_ghr     = 8'h00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("ready_after_rst", 32'(bp.ready), 32'd0);
    k = 0;
    while (bp.ready !== 1'b1 && k < 400) begin
      @(posedge clk); #1;
      k++;
      if (k == 100) begin
        check("init_pred_taken", 32'(bp.pred_taken), 32'd0);
        check("init_pred_target", bp.pred_target, 32'h104);
        check("init_pred_ghr", 32'(bp.pred_ghr), 32'd0);
      end
    end
    check("init_cycles", 32'(k), 32'd256);
    bp.update_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    bp.lookup_pc = '0; bp.update_valid = 1'b0; bp.update_pc = '0; bp.update_taken = 1'b0;
    bp.update_target = '0; bp.update_is_cond = 1'b0; bp.update_ghr = '0;

    //  pr  lookup   uv upd_pc   t  target   c  ughr   exp_t exp_tgt  exp_ghr
    add(1, 32'h100,  0, 32'h0,    0, 32'h0,   0, 8'h00, 0, 32'h104,  8'h00);
    add(0, 32'h100,  1, 32'h100,  1, 32'h80,  1, 8'h00, 0, 32'h104,  8'h00);
    add(0, 32'h100,  1, 32'h100,  1, 32'h80,  1, 8'h01, 1, 32'h80,   8'h01);
    add(0, 32'h100,  0, 32'h0,    0, 32'h0,   0, 8'h00, 1, 32'h80,   8'h03);
    add(0, 32'h100,  1, 32'h1100, 1, 32'h900, 0, 8'h03, 1, 32'h80,   8'h03);
    add(0, 32'h100,  0, 32'h0,    0, 32'h0,   0, 8'h00, 0, 32'h104,  8'h03);
    add(0, 32'h1100, 0, 32'h0,    0, 32'h0,   0, 8'h00, 1, 32'h900,  8'h03);
    add(0, 32'h200,  1, 32'h200,  1, 32'h400, 0, 8'h03, 0, 32'h204,  8'h03);
    add(0, 32'h200,  0, 32'h0,    0, 32'h0,   0, 8'h00, 1, 32'h400,  8'h03);
    add(0, 32'h1100, 0, 32'h0,    0, 32'h0,   0, 8'h00, 0, 32'h1104, 8'h03);
    add(1, 32'h100,  0, 32'h0,    0, 32'h0,   0, 8'h00, 0, 32'h104,  8'h00);
    add(0, 32'h100,  1, 32'h100,  1, 32'h80,  1, 8'h00, 0, 32'h104,  8'h00);
    add(0, 32'h100,  1, 32'h100,  1, 32'h80,  1, 8'h01, 1, 32'h80,   8'h01);
    add(0, 32'h100,  1, 32'h100,  1, 32'h80,  1, 8'h03, 1, 32'h80,   8'h03);
    add(0, 32'h100,  1, 32'h100,  1, 32'h80,  1, 8'h07, 1, 32'h80,   8'h07);
    add(0, 32'h100,  1, 32'h100,  1, 32'h80,  1, 8'h0F, 1, 32'h80,   8'h0F);
    add(0, 32'h100,  1, 32'h100,  0, 32'h0,   1, 8'h1F, 1, 32'h80,   8'h1F);
    add(0, 32'h100,  1, 32'h100,  0, 32'h0,   1, 8'h3E, 1, 32'h80,   8'h3E);
    add(0, 32'h100,  0, 32'h0,    0, 32'h0,   0, 8'h00, 0, 32'h104,  8'h7C);

    foreach (vecs[i]) begin
      if (vecs[i].pre_reset) reset_walk();
      bp.lookup_pc      = vecs[i].lpc;
      bp.update_valid   = vecs[i].uv;
      bp.update_pc      = vecs[i].upc;
      bp.update_taken   = vecs[i].ut;
      bp.update_target  = vecs[i].utgt;
      bp.update_is_cond = vecs[i].uc;
      bp.update_ghr     = vecs[i].ughr;
      e.taken  = vecs[i].exp_taken;
      e.target = vecs[i].exp_target;
      e.ghr    = vecs[i].exp_ghr;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("v%0d_ready", i), 32'(bp.ready), 32'd1);
      check($sformatf("v%0d_taken", i), 32'(bp.pred_taken), 32'(e.taken));
      check($sformatf("v%0d_target", i), bp.pred_target, e.target);
      check($sformatf("v%0d_ghr", i), 32'(bp.pred_ghr), 32'(e.ghr));
      @(posedge clk); #1;
    end
    bp.update_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
